// File: rtl/scan_sel_gen.sv
// Time-multiplexed digit scanner that drives a 2-to-4 decoder, blanking its enable around every select change.
// Optional leading-zero blanking is compiled in with `define SCAN_LZ_BLANK_EN.
module scan_sel_gen #(
  parameter int DIV   = 4,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] dig_in,
  input  logic        dig_ld,
  output logic [1:0]  sel,
  output logic        sel_en,
  output logic [3:0]  hex_out,
  output logic        frame_done
);

  localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GUARD_S} state_t;

  state_t        state;
  logic [SW-1:0] slot_cnt;
  logic [GW-1:0] guard_cnt;
  logic [15:0]   pending;
  logic [15:0]   active;

  logic [15:0] next_frame;
  logic [1:0]  sel_inc;
  logic        wrap;
  logic [15:0] active_adv;
  logic        en_cur;
  logic        en_adv;

  // A load strobe coinciding with a frame start wins over the pending copy.
  assign next_frame = dig_ld ? dig_in : pending;
  assign sel_inc    = sel + 2'd1;
  assign wrap       = (sel == 2'd3);
  assign active_adv = wrap ? next_frame : active;

  function automatic logic [3:0] nib(input logic [15:0] a, input logic [1:0] s);
    return a[{s, 2'b00} +: 4];
  endfunction

`ifdef SCAN_LZ_BLANK_EN
  function automatic logic lz_en(input logic [15:0] a, input logic [1:0] s);
    case (s)
      2'd3:    return a[15:12] != 4'd0;
      2'd2:    return a[15:8]  != 8'd0;
      2'd1:    return a[15:4]  != 12'd0;
      default: return 1'b1;
    endcase
  endfunction
  assign en_cur = lz_en(active, sel);
  assign en_adv = lz_en(active_adv, sel_inc);
`else
  assign en_cur = 1'b1;
  assign en_adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      guard_cnt  <= '0;
      pending    <= '0;
      active     <= '0;
      sel        <= '0;
      sel_en     <= 1'b0;
      hex_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (dig_ld) pending <= dig_in;
      case (state)
        IDLE: begin
          if (run) begin
            state     <= ACTIVE;
            sel       <= 2'd0;
            sel_en    <= 1'b1;
            active    <= next_frame;
            hex_out   <= next_frame[3:0];
            slot_cnt  <= '0;
            guard_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (!run) begin
            state     <= IDLE;
            sel_en    <= 1'b0;
            slot_cnt  <= '0;
            guard_cnt <= '0;
          end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            if (GUARD == 0) begin
              sel        <= sel_inc;
              sel_en     <= en_adv;
              hex_out    <= nib(active_adv, sel_inc);
              active     <= active_adv;
              frame_done <= wrap;
            end else begin
              state     <= GUARD_S;
              sel_en    <= 1'b0;
              guard_cnt <= '0;
            end
          end else begin
            slot_cnt <= slot_cnt + SW'(1);
          end
        end
        GUARD_S: begin
          if (!run) begin
            state     <= IDLE;
            sel_en    <= 1'b0;
            slot_cnt  <= '0;
            guard_cnt <= '0;
          end else begin
            // Select moves on the first guard edge so it settles before enable returns.
            if (guard_cnt == '0) begin
              sel        <= sel_inc;
              hex_out    <= nib(active_adv, sel_inc);
              active     <= active_adv;
              frame_done <= wrap;
            end
            if (guard_cnt == GUARD_LAST) begin
              state     <= ACTIVE;
              sel_en    <= en_cur;
              guard_cnt <= '0;
            end else begin
              guard_cnt <= guard_cnt + GW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen at DIV=4, GUARD=2 (6-cycle slot, 24-cycle frame).
// Define SCAN_LZ_BLANK_EN here too when the design is built with leading-zero blanking.
module tb_scan_sel_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] dig_in;
  logic        dig_ld;
  logic [1:0]  sel;
  logic        sel_en;
  logic [3:0]  hex_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  scan_sel_gen #(.DIV(4), .GUARD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .dig_in     (dig_in),
    .dig_ld     (dig_ld),
    .sel        (sel),
    .sel_en     (sel_en),
    .hex_out    (hex_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected {sel, sel_en, hex_out, frame_done} after edge n (edge 0 = leaving IDLE).
  function automatic logic [7:0] exp_vec(input int n, input logic [15:0] d);
    int pos;
    logic [1:0] s;
    logic en;
    pos = n % 6;
    s   = 2'(((n + 1) / 6) % 4);
    en  = (pos < 4);
`ifdef SCAN_LZ_BLANK_EN
    if (s == 2'd3 && d[15:12] == 4'd0) en = 1'b0;
    if (s == 2'd2 && d[15:8] == 8'd0) en = 1'b0;
    if (s == 2'd1 && d[15:4] == 12'd0) en = 1'b0;
`endif
    return {s, en, d[{s, 2'b00} +: 4], ((n % 24) == 23)};
  endfunction

  task automatic start_scan(input logic [15:0] d);
    rst_n = 1'b0; run = 1'b0; dig_ld = 1'b0; dig_in = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 dig_in = d; dig_ld = 1'b1;
    @(posedge clk); #1 dig_ld = 1'b0; run = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; dig_ld = 1'b1; dig_in = 16'hFFFF;
    #3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({sel, sel_en, hex_out, frame_done} !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got %b exp %b", i, {sel, sel_en, hex_out, frame_done}, 8'h00);
      end
    end
    run = 1'b0; dig_ld = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({sel, sel_en, hex_out, frame_done} !== 8'h00) begin
        errors++;
        $display("FAIL idle_after_reset cyc=%0d got %b exp %b", i, {sel, sel_en, hex_out, frame_done}, 8'h00);
      end
    end
    run = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sel, sel_en, hex_out, frame_done} !== 8'h20) begin
      errors++;
      $display("FAIL first_run_zero_digits got %b exp %b", {sel, sel_en, hex_out, frame_done}, 8'h20);
    end
    run = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_scan();
    logic [1:0] prev_sel;
    logic prev_en;
    logic [7:0] e;
    start_scan(16'h4321);
    prev_sel = 2'd0; prev_en = 1'b0;
    for (int n = 0; n < 48; n++) begin
      @(posedge clk); #1;
      e = exp_vec(n, 16'h4321);
      checks++;
      if ({sel, sel_en, hex_out, frame_done} !== e) begin
        errors++;
        $display("FAIL scan n=%0d got %b exp %b", n, {sel, sel_en, hex_out, frame_done}, e);
      end
      if (n > 0 && sel != prev_sel) begin
        checks++;
        if (sel_en !== 1'b0 || prev_en !== 1'b0) begin
          errors++;
          $display("FAIL glitch n=%0d sel_en=%b prev_en=%b exp 0,0", n, sel_en, prev_en);
        end
      end
      prev_sel = sel; prev_en = sel_en;
    end
  endtask

  task automatic test_load_midframe();
    logic [7:0] e;
    logic [15:0] d;
    int fr;
    start_scan(16'h4321);
    for (int n = 0; n < 72; n++) begin
      @(posedge clk); #1;
      fr = (n + 1) / 24;
      d  = (fr == 0) ? 16'h4321 : (fr == 1) ? 16'hABCD : 16'h5678;
      e  = exp_vec(n, d);
      checks++;
      if ({sel, sel_en, hex_out, frame_done} !== e) begin
        errors++;
        $display("FAIL load n=%0d got %b exp %b", n, {sel, sel_en, hex_out, frame_done}, e);
      end
      // Load ABCD mid-frame, then 5678 so it is sampled on the wrap edge (47).
      dig_ld = (n == 10) || (n == 46);
      dig_in = (n == 10) ? 16'hABCD : (n == 46) ? 16'h5678 : 16'h0000;
    end
    dig_ld = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [7:0] e;
    logic [7:0] ed;
    int drops [2] = '{16, 22};
    for (int k = 0; k < 2; k++) begin
      start_scan(16'h4321);
      for (int n = 0; n <= drops[k]; n++) begin
        @(posedge clk); #1;
        e = exp_vec(n, 16'h4321);
        checks++;
        if ({sel, sel_en, hex_out, frame_done} !== e) begin
          errors++;
          $display("FAIL drop_pre d=%0d n=%0d got %b exp %b", drops[k], n, {sel, sel_en, hex_out, frame_done}, e);
        end
      end
      run = 1'b0;
      ed = exp_vec(drops[k], 16'h4321);
      e  = {ed[7:6], 1'b0, ed[4:1], 1'b0};
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        checks++;
        if ({sel, sel_en, hex_out, frame_done} !== e) begin
          errors++;
          $display("FAIL drop_idle d=%0d cyc=%0d got %b exp %b", drops[k], i, {sel, sel_en, hex_out, frame_done}, e);
        end
      end
      run = 1'b1;
      for (int n = 0; n < 8; n++) begin
        @(posedge clk); #1;
        e = exp_vec(n, 16'h4321);
        checks++;
        if ({sel, sel_en, hex_out, frame_done} !== e) begin
          errors++;
          $display("FAIL rerun d=%0d n=%0d got %b exp %b", drops[k], n, {sel, sel_en, hex_out, frame_done}, e);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    start_scan(16'h4321);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, sel_en, hex_out, frame_done} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", {sel, sel_en, hex_out, frame_done}, 8'h00);
    end
    run = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sel, sel_en, hex_out, frame_done} !== 8'h00) begin
      errors++;
      $display("FAIL after_async_reset got %b exp %b", {sel, sel_en, hex_out, frame_done}, 8'h00);
    end
  endtask

  task automatic test_lz_blank();
    logic [7:0] e;
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    for (int k = 0; k < 2; k++) begin
      start_scan(vals[k]);
      for (int n = 0; n < 24; n++) begin
        @(posedge clk); #1;
        e = exp_vec(n, vals[k]);
        checks++;
        if ({sel, sel_en, hex_out, frame_done} !== e) begin
          errors++;
          $display("FAIL lz d=%h n=%0d got %b exp %b", vals[k], n, {sel, sel_en, hex_out, frame_done}, e);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; dig_in = 16'h0; dig_ld = 1'b0;
    test_reset();
    test_scan();
    test_load_midframe();
    test_run_drop();
    test_async_reset();
    test_lz_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
